// File: rtl/barra_pkg.sv
// barra_pkg: shared state/direction types and coordinate width for the barra paddle controller.
package barra_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {IDLE, FIRST, WAIT, REPEAT} state_e;

    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;

    // Both buttons held at once cancel each other out.
    function automatic dir_e decodeRequest(input logic upLvl, input logic downLvl);
        if (upLvl && !downLvl) begin
            return DIR_UP;
        end else if (downLvl && !upLvl) begin
            return DIR_DOWN;
        end else begin
            return DIR_NONE;
        end
    endfunction

endpackage

// File: rtl/barra_ctrl_if.sv
// barra_ctrl_if: buttons, frame tick and positions into barra_ctrl, step pulses out.
interface barra_ctrl_if;
    import barra_pkg::*;

    logic               btn_up;
    logic               btn_down;
    logic               frame_tick;
    logic [COORD_W-1:0] bar_y;
    logic [COORD_W-1:0] ball_y;
    logic               auto_mode;
    logic               up;
    logic               down;
    logic               moving;

    modport master (
        output btn_up, btn_down, frame_tick, bar_y, ball_y, auto_mode,
        input  up, down, moving
    );

    modport slave (
        input  btn_up, btn_down, frame_tick, bar_y, ball_y, auto_mode,
        output up, down, moving
    );

endinterface

// File: rtl/barra_debounce.sv
// barra_debounce: 2-flop synchronizer followed by a debouncer that accepts a new level
// only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module barra_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the current level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/barra_ctrl.sv
// barra_ctrl: turns debounced buttons into frame-paced up/down step pulses for barra.
// Optional ball tracking is compiled in with BARRA_CTRL_AUTO_EN.
module barra_ctrl
    import barra_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_FRAMES   = 8,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 400,
    parameter int AUTO_DEADBAND   = 4
) (
    input  logic        clk,
    input  logic        reset,
    barra_ctrl_if.slave bus
);

    localparam int CMP_W   = COORD_W + 1;
    localparam int FRAME_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(REPEAT_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_SAT  = FRAME_W'(REPEAT_FRAMES);
    localparam logic [CMP_W-1:0]   Y_MIN_X    = CMP_W'(Y_MIN);
    localparam logic [CMP_W-1:0]   Y_MAX_X    = CMP_W'(Y_MAX);

    logic               upLvl;
    logic               downLvl;
    dir_e               req;
    logic [CMP_W-1:0]   barX;
    logic               upOk;
    logic               downOk;
    logic               stepUp;
    logic               stepDown;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;
    logic               up_q, up_d;
    logic               down_q, down_d;

    barra_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebUp (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (bus.btn_up),
        .level_o (upLvl)
    );

    barra_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebDown (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (bus.btn_down),
        .level_o (downLvl)
    );

    assign req      = decodeRequest(upLvl, downLvl);
    assign barX     = {1'b0, bus.bar_y};
    assign upOk     = barX > Y_MIN_X;
    assign downOk   = barX < Y_MAX_X;
    assign stepUp   = (dir_q == DIR_UP) && upOk;
    assign stepDown = (dir_q == DIR_DOWN) && downOk;

`ifdef BARRA_CTRL_AUTO_EN
    logic             autoMode_q;
    logic [CMP_W-1:0] ballX;
    logic             autoUp;
    logic             autoDown;

    assign ballX    = {1'b0, bus.ball_y};
    assign autoDown = ballX > (barX + CMP_W'(AUTO_DEADBAND));
    assign autoUp   = (ballX + CMP_W'(AUTO_DEADBAND)) < barX;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            autoMode_q <= 1'b0;
        end else begin
            autoMode_q <= bus.auto_mode;
        end
    end
`endif

    // Limit gating only masks the pulse; the sequence keeps advancing.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        frameCnt_d = frameCnt_q;
        up_d       = 1'b0;
        down_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != DIR_NONE) begin
                    state_d = FIRST;
                    dir_d   = req;
                end
            end
            FIRST: begin
                if (req != dir_q) begin
                    state_d = IDLE;
                end else begin
                    up_d       = stepUp;
                    down_d     = stepDown;
                    frameCnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (req != dir_q) begin
                    state_d = IDLE;
                end else if (bus.frame_tick) begin
                    if (frameCnt_q == FRAME_LAST) begin
                        frameCnt_d = FRAME_SAT;
                        state_d    = REPEAT;
                    end else begin
                        frameCnt_d = frameCnt_q + FRAME_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (req != dir_q) begin
                    state_d = IDLE;
                end else if (bus.frame_tick) begin
                    up_d   = stepUp;
                    down_d = stepDown;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BARRA_CTRL_AUTO_EN
        if (bus.auto_mode != autoMode_q) begin
            state_d = IDLE;
            up_d    = 1'b0;
            down_d  = 1'b0;
        end else if (bus.auto_mode) begin
            state_d = IDLE;
            down_d  = bus.frame_tick && autoDown && downOk;
            up_d    = bus.frame_tick && !autoDown && autoUp && upOk;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= DIR_NONE;
            frameCnt_q <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            frameCnt_q <= frameCnt_d;
            up_q       <= up_d;
            down_q     <= down_d;
        end
    end

    assign bus.up   = up_q;
    assign bus.down = down_q;
`ifdef BARRA_CTRL_AUTO_EN
    assign bus.moving = (state_q != IDLE) || up_q || down_q;
`else
    assign bus.moving = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_barra_ctrl.sv
// tb_barra_ctrl: directed and randomized stimulus for barra_ctrl, compared every cycle
// against a behavioural model; auto-mode scenarios run when BARRA_CTRL_AUTO_EN is defined.
module tb_barra_ctrl;

    localparam int DEB         = 4;
    localparam int RPT         = 2;
    localparam int YMIN        = 0;
    localparam int YMAX        = 400;
    localparam int DBAND       = 4;
    localparam int TICK_PERIOD = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   cmpEn    = 1'b0;
    int   tickCnt  = 0;

    bit   mLvlUp, mLvlDn;
    bit   hUp [0:DEB+1];
    bit   hDn [0:DEB+1];
    int   mDir;
    bit   mFirst;
    int   mTicks;
    bit   mUp, mDn;
    bit   mAutoPrev;

    barra_ctrl_if bus ();

    barra_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_FRAMES   (RPT),
        .Y_MIN           (YMIN),
        .Y_MAX           (YMAX),
        .AUTO_DEADBAND   (DBAND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.frame_tick = 1'b0;
        forever begin
            @(negedge clk);
            tickCnt++;
            bus.frame_tick = ((tickCnt % TICK_PERIOD) == 0);
        end
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, actual, expected);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic bu, input logic bd, input int cycles);
        bus.btn_up   = bu;
        bus.btn_down = bd;
        repeat (cycles) @(negedge clk);
    endtask

    // Returns on the rising edge that samples a frame tick.
    task automatic waitTick();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * TICK_PERIOD && !seen; i++) begin
            @(posedge clk);
            seen = bus.frame_tick;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL tick_timeout at %0t: got no tick expected tick", $time);
        end
    endtask

    // Behavioural reference: levels accepted after DEB identical synchronized samples,
    // first step on request, then one step per tick once RPT ticks have elapsed.
    always @(posedge clk) begin : model_p
        int req;
        int bar;
        int ball;
        bit flipUp, flipDn, upOk, dnOk, pU, pD, autoChg, autoOn;
        if (reset) begin
            mLvlUp = 0; mLvlDn = 0; mDir = 0; mFirst = 0; mTicks = 0;
            mUp = 0; mDn = 0; mAutoPrev = 0;
            for (int i = 0; i <= DEB + 1; i++) begin
                hUp[i] = 0;
                hDn[i] = 0;
            end
        end else begin
            req = (mLvlUp && !mLvlDn) ? 1 : ((mLvlDn && !mLvlUp) ? 2 : 0);
            flipUp = 1;
            flipDn = 1;
            for (int i = 1; i <= DEB; i++) begin
                if (hUp[i] == mLvlUp) flipUp = 0;
                if (hDn[i] == mLvlDn) flipDn = 0;
            end
            for (int i = DEB + 1; i > 0; i--) begin
                hUp[i] = hUp[i-1];
                hDn[i] = hDn[i-1];
            end
            hUp[0] = bus.btn_up;
            hDn[0] = bus.btn_down;
            bar  = int'(bus.bar_y);
            ball = int'(bus.ball_y);
            upOk = bar > YMIN;
            dnOk = bar < YMAX;
            pU = 0;
            pD = 0;
            autoChg = 0;
            autoOn  = 0;
`ifdef BARRA_CTRL_AUTO_EN
            autoChg   = (bus.auto_mode != mAutoPrev);
            autoOn    = bus.auto_mode;
            mAutoPrev = bus.auto_mode;
`endif
            if (autoChg) begin
                mDir = 0;
            end else if (autoOn) begin
                mDir = 0;
                if (bus.frame_tick) begin
                    if (ball > bar + DBAND) pD = dnOk;
                    else if (ball + DBAND < bar) pU = upOk;
                end
            end else if (mDir == 0) begin
                if (req != 0) begin
                    mDir   = req;
                    mFirst = 1;
                end
            end else if (req != mDir) begin
                mDir = 0;
            end else if (mFirst) begin
                mFirst = 0;
                mTicks = 0;
                pU = (mDir == 1) && upOk;
                pD = (mDir == 2) && dnOk;
            end else if (bus.frame_tick) begin
                if (mTicks < RPT) begin
                    mTicks++;
                end else begin
                    pU = (mDir == 1) && upOk;
                    pD = (mDir == 2) && dnOk;
                end
            end
            mUp = pU;
            mDn = pD;
            if (flipUp) mLvlUp = !mLvlUp;
            if (flipDn) mLvlDn = !mLvlDn;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (cmpEn) begin
            checkOutput("model_up", bus.up, mUp);
            checkOutput("model_down", bus.down, mDn);
            checkOutput("model_moving", bus.moving, (mDir != 0) || mUp || mDn);
            checkOutput("exclusive", bus.up & bus.down, 1'b0);
        end
    end

    initial begin
        int nt;
        int pulses;
        bit t;
        int pat, len, sel, bar;

        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.bar_y     = 10'd100;
        bus.ball_y    = 10'd0;
        bus.auto_mode = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_up", bus.up, 1'b0);
        checkOutput("reset_down", bus.down, 1'b0);
        checkOutput("reset_moving", bus.moving, 1'b0);
        cmpEn = 1'b1;

        $display("[TB] glitch rejection");
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 3);
        bus.btn_up = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #2;
            checkOutput("glitch_up", bus.up, 1'b0);
            checkOutput("glitch_moving", bus.moving, 1'b0);
        end
        @(negedge clk);

        $display("[TB] held up: first step then auto-repeat");
        waitTick();
        @(negedge clk);
        bus.btn_up = 1'b1;
        nt = 0;
        pulses = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            t = bus.frame_tick;
            #2;
            if (k <= 10) begin
                checkOutput("first_up", bus.up, k == 8);
                checkOutput("first_moving", bus.moving, k >= 7);
                if (k == 8) checkOutput("model_pin_first_up", mUp, 1'b1);
            end else begin
                if (t) nt++;
                checkOutput("repeat_up", bus.up, t && (nt > RPT));
                if (bus.up) pulses++;
            end
        end
        checkValue("repeat_pulses", pulses, 2);
        @(negedge clk);

        $display("[TB] both buttons then release up");
        applyStimulus(1'b0, 1'b0, 12);
        applyStimulus(1'b1, 1'b1, 0);
        repeat (30) begin
            @(posedge clk);
            #2;
            checkOutput("both_up", bus.up, 1'b0);
            checkOutput("both_down", bus.down, 1'b0);
            checkOutput("both_moving", bus.moving, 1'b0);
        end
        @(negedge clk);
        bus.btn_up = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #2;
            checkOutput("reverse_down", bus.down, k == 8);
        end
        @(negedge clk);

        $display("[TB] bottom limit");
        bus.bar_y = 10'd400;
        repeat (80) begin
            @(posedge clk);
            #2;
            checkOutput("limit_down", bus.down, 1'b0);
            checkOutput("limit_moving", bus.moving, 1'b1);
        end
        @(negedge clk);
        bus.bar_y = 10'd399;
        waitTick();
        #2;
        checkOutput("limit_release_down", bus.down, 1'b1);
        checkOutput("model_pin_release", mDn, 1'b1);

        $display("[TB] async reset during repeat");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_up", bus.up, 1'b0);
        checkOutput("async_reset_down", bus.down, 1'b0);
        checkOutput("async_reset_moving", bus.moving, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3);
        bus.bar_y = 10'd100;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
            checkOutput("post_reset_idle", bus.moving, 1'b0);
        end
        @(negedge clk);

`ifdef BARRA_CTRL_AUTO_EN
        $display("[TB] auto tracking");
        bus.auto_mode = 1'b1;
        bus.ball_y    = 10'd200;
        bus.bar_y     = 10'd100;
        repeat (2) @(negedge clk);
        waitTick();
        #2;
        checkOutput("auto_down", bus.down, 1'b1);
        checkOutput("auto_up", bus.up, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("auto_down_single", bus.down, 1'b0);
        @(negedge clk);
        bus.bar_y = 10'd198;
        repeat (50) begin
            @(posedge clk);
            #2;
            checkOutput("auto_deadband_down", bus.down, 1'b0);
            checkOutput("auto_deadband_up", bus.up, 1'b0);
        end
        @(negedge clk);
        bus.auto_mode = 1'b0;
        applyStimulus(1'b0, 1'b0, 2);
`endif

        $display("[TB] randomized traffic");
        for (int s = 0; s < 120; s++) begin
            pat = int'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 150))
                                               : int'($urandom_range(1, 30));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       bar = 0;
                1:       bar = 1;
                2:       bar = 399;
                3:       bar = 400;
                default: bar = int'($urandom_range(0, 1023));
            endcase
            bus.bar_y = 10'(bar);
`ifdef BARRA_CTRL_AUTO_EN
            if ($urandom_range(0, 7) == 0) bus.auto_mode = !bus.auto_mode;
            bus.ball_y = 10'($urandom_range(0, 1023));
`endif
            applyStimulus(pat[0], pat[1], len);
        end

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
